// File: rtl/ooo_pkg.sv
// Shared out-of-order core definitions: datapath widths, functional-unit
// indices and the common data bus (CDB) packet layout.
package ooo_pkg;

  localparam int XLEN  = 32;
  localparam int TAG_W = 6;
  localparam int SRC_W = 2;

  // Functional-unit indices as seen by the CDB arbiter.
  localparam int FU_ALU    = 0;
  localparam int FU_LSU    = 1;
  localparam int FU_MULDIV = 2;
  localparam int FU_BR     = 3;
  localparam int N_FU      = 4;

  // One CDB broadcast: valid, physical destination tag, result, producer.
  typedef struct packed {
    logic             en;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  data;
    logic [SRC_W-1:0] src;
  } cdb_pkt_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational requester picker for the CDB arbiter.
// Scans requests starting at i_ptr, wrapping modulo N, and grants the first
// one found. With CDB_FIXED_PRIO_EN defined the scan always starts at index 0
// (lowest index wins) and i_ptr is ignored.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  // One extra bit so base+offset cannot overflow before the explicit wrap;
  // N need not be a power of two.
  logic [IW:0] w_base;
  logic [IW:0] w_pos;

  // Rotate-and-priority-encode: first requester at or after the base wins.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
`ifdef CDB_FIXED_PRIO_EN
    w_base = '0;
`else
    w_base = {1'b0, i_ptr};
`endif
    w_pos = '0;
    for (int k = 0; k < N; k++) begin
      w_pos = w_base + (IW+1)'(k);
      if (w_pos >= (IW+1)'(N)) begin
        w_pos = w_pos - (IW+1)'(N);
      end
      if (!o_any && i_req[w_pos[IW-1:0]]) begin
        o_any                 = 1'b1;
        o_idx                 = w_pos[IW-1:0];
        o_gnt[w_pos[IW-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: grants at most one functional-unit result per
// cycle (valid/ready) and registers it onto the CDB one cycle later.
// Build option CDB_FIXED_PRIO_EN: fixed priority (ALU > LSU > MULDIV > BR)
// instead of round-robin; the round-robin pointer then does not exist.
//
// Handshake: FU i transfers when req_valid_i[i] && req_ready_o[i]. The FU
// holds valid/tag/data stable until accepted (it may drop only on flush).
// req_ready_o is one-hot or zero and is forced to zero during reset or flush.
// The CDB itself is never backpressured.
module cdb_arbiter
  import ooo_pkg::*;
#(
  parameter int N_REQ = N_FU,
  parameter int TAG_W = ooo_pkg::TAG_W,
  parameter int XLEN  = ooo_pkg::XLEN,
  parameter int SRC_W = ooo_pkg::SRC_W
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [N_REQ-1:0]       req_valid_i,
  input  logic [N_REQ*TAG_W-1:0] req_tag_i,
  input  logic [N_REQ*XLEN-1:0]  req_data_i,
  output logic [N_REQ-1:0]       req_ready_o,
  input  logic                   flush_i,
  output logic                   cdb_en_o,
  output logic [TAG_W-1:0]       cdb_reg_addr_o,
  output logic [XLEN-1:0]        cdb_data_o,
  output logic [SRC_W-1:0]       cdb_src_o
);

  logic [N_REQ-1:0] w_req_eff;
  logic [N_REQ-1:0] w_gnt;
  logic [SRC_W-1:0] w_gnt_idx;
  logic             w_any;
  logic [SRC_W-1:0] w_rr_ptr;

  logic             r_cdb_en;
  logic [TAG_W-1:0] r_cdb_tag;
  logic [XLEN-1:0]  r_cdb_data;
  logic [SRC_W-1:0] r_cdb_src;

  // Nothing is accepted while in reset or during a flush cycle.
  assign w_req_eff   = (reset_i || flush_i) ? '0 : req_valid_i;
  assign req_ready_o = w_gnt;

  rr_pick #(
    .N  (N_REQ),
    .IW (SRC_W)
  ) u_pick (
    .i_req (w_req_eff),
    .i_ptr (w_rr_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_gnt_idx),
    .o_any (w_any)
  );

`ifdef CDB_FIXED_PRIO_EN
  assign w_rr_ptr = '0;
`else
  logic [SRC_W-1:0] r_rr_ptr;

  // Round-robin pointer: moves just past the winner on acceptance, explicit wrap.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_rr_ptr <= '0;
    end else if (w_any) begin
      r_rr_ptr <= (w_gnt_idx == SRC_W'(N_REQ-1)) ? '0 : w_gnt_idx + 1'b1;
    end
  end

  assign w_rr_ptr = r_rr_ptr;
`endif

  // CDB output register: capture the winner; otherwise drop en and hold payload.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_cdb_en   <= 1'b0;
      r_cdb_tag  <= '0;
      r_cdb_data <= '0;
      r_cdb_src  <= '0;
    end else if (w_any) begin
      r_cdb_en   <= 1'b1;
      r_cdb_tag  <= req_tag_i[w_gnt_idx*TAG_W +: TAG_W];
      r_cdb_data <= req_data_i[w_gnt_idx*XLEN +: XLEN];
      r_cdb_src  <= w_gnt_idx;
    end else begin
      r_cdb_en   <= 1'b0;
    end
  end

  assign cdb_en_o       = r_cdb_en;
  assign cdb_reg_addr_o = r_cdb_tag;
  assign cdb_data_o     = r_cdb_data;
  assign cdb_src_o      = r_cdb_src;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed testbench for cdb_arbiter: reset, round-robin rotation and wrap,
// single requester, contention, flush, idle/hold and reset-over-flush.
// Expected values follow the CDB_FIXED_PRIO_EN setting of the build.
module tb_cdb_arbiter;
  import ooo_pkg::*;

  localparam int N_REQ = 4;
  localparam int PKT_W = $bits(cdb_pkt_t);
`ifdef CDB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  // Clock and DUT signals
  logic                   clk_i = 1'b0;
  logic                   reset_i;
  logic [N_REQ-1:0]       req_valid_i;
  logic [N_REQ*TAG_W-1:0] req_tag_i;
  logic [N_REQ*XLEN-1:0]  req_data_i;
  logic [N_REQ-1:0]       req_ready_o;
  logic                   flush_i;
  logic                   cdb_en_o;
  logic [TAG_W-1:0]       cdb_reg_addr_o;
  logic [XLEN-1:0]        cdb_data_o;
  logic [SRC_W-1:0]       cdb_src_o;

  always #5 clk_i = ~clk_i;

  cdb_arbiter dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .req_valid_i    (req_valid_i),
    .req_tag_i      (req_tag_i),
    .req_data_i     (req_data_i),
    .req_ready_o    (req_ready_o),
    .flush_i        (flush_i),
    .cdb_en_o       (cdb_en_o),
    .cdb_reg_addr_o (cdb_reg_addr_o),
    .cdb_data_o     (cdb_data_o),
    .cdb_src_o      (cdb_src_o)
  );

  // Scoreboard
  logic [PKT_W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_fu(input int i, input logic v, input logic [TAG_W-1:0] t,
                        input logic [XLEN-1:0] d);
    req_valid_i[i]              = v;
    req_tag_i[i*TAG_W +: TAG_W] = t;
    req_data_i[i*XLEN +: XLEN]  = d;
  endtask

  task automatic load_defaults();
    for (int i = 0; i < N_REQ; i++) begin
      set_fu(i, 1'b1, TAG_W'(16 + i), 32'hA000_0000 + XLEN'(i));
    end
  endtask

  // One arbitration cycle: check the grant, then the broadcast after the edge.
  task automatic cycle(input string nm, input logic [N_REQ-1:0] exp_rdy);
    cdb_pkt_t pkt;
    int       idx;
    #1;
    check({nm, ".rdy"}, 64'(req_ready_o), 64'(exp_rdy));
    if (exp_rdy != '0) begin
      idx = 0;
      for (int i = 0; i < N_REQ; i++) if (exp_rdy[i]) idx = i;
      pkt.en   = 1'b1;
      pkt.tag  = req_tag_i[idx*TAG_W +: TAG_W];
      pkt.data = req_data_i[idx*XLEN +: XLEN];
      pkt.src  = SRC_W'(idx);
      exp_q.push_back(PKT_W'(pkt));
    end
    tick();
    if (exp_q.size() > 0) begin
      pkt = cdb_pkt_t'(exp_q.pop_front());
      check({nm, ".en"},   64'(cdb_en_o),       64'(1'b1));
      check({nm, ".tag"},  64'(cdb_reg_addr_o), 64'(pkt.tag));
      check({nm, ".data"}, 64'(cdb_data_o),     64'(pkt.data));
      check({nm, ".src"},  64'(cdb_src_o),      64'(pkt.src));
    end else begin
      check({nm, ".en0"}, 64'(cdb_en_o), 64'(1'b0));
    end
  endtask

  task automatic check_cleared(input string nm);
    check({nm, ".en"},   64'(cdb_en_o),       64'd0);
    check({nm, ".tag"},  64'(cdb_reg_addr_o), 64'd0);
    check({nm, ".data"}, 64'(cdb_data_o),     64'd0);
    check({nm, ".src"},  64'(cdb_src_o),      64'd0);
  endtask

  initial begin
    reset_i     = 1'b1;
    flush_i     = 1'b0;
    req_valid_i = '0;
    req_tag_i   = '0;
    req_data_i  = '0;
    load_defaults();

    // Reset held two cycles with every FU requesting.
    for (int c = 0; c < 2; c++) begin
      #1;
      check("rst.rdy", 64'(req_ready_o), 64'd0);
      tick();
      check_cleared("rst");
    end
    reset_i = 1'b0;

    // All four valid and held: ALU, LSU, MULDIV, BR, ALU (wrap 3->0).
    for (int k = 0; k < 5; k++) begin
      cycle($sformatf("rr%0d", k), FIXED ? 4'b0001 : N_REQ'(1 << (k % N_REQ)));
    end

    // Single LSU request.
    req_valid_i = '0;
    set_fu(FU_LSU, 1'b1, 6'h15, 32'hDEAD_BEEF);
    cycle("lsu", 4'b0010);

    // MULDIV alone twice: the second time the pointer sits at 3.
    req_valid_i = '0;
    set_fu(FU_MULDIV, 1'b1, 6'h2A, 32'h1234_5678);
    cycle("md_a", 4'b0100);
    set_fu(FU_MULDIV, 1'b1, 6'h2B, 32'h8765_4321);
    cycle("md_b", 4'b0100);

    // BR and ALU together with pointer at 3; then the loser alone.
    req_valid_i = '0;
    set_fu(FU_ALU, 1'b1, 6'h01, 32'h0000_00A1);
    set_fu(FU_BR,  1'b1, 6'h3F, 32'hB0B0_0003);
    cycle("br_alu", FIXED ? 4'b0001 : 4'b1000);
    req_valid_i = FIXED ? 4'b1000 : 4'b0001;
    cycle("loser", FIXED ? 4'b1000 : 4'b0001);

    // Flush with everyone valid.
    load_defaults();
    cycle("pre_flush", FIXED ? 4'b0001 : 4'b0010);
    flush_i = 1'b1;
    #1;
    check("flush.inflight_en",  64'(cdb_en_o),  64'd1);
    check("flush.inflight_src", 64'(cdb_src_o), FIXED ? 64'd0 : 64'd1);
    cycle("flush", 4'b0000);
    flush_i = 1'b0;
    cycle("post_flush", FIXED ? 4'b0001 : 4'b0100);

    // Idle for five cycles: payload holds, pointer must not move.
    req_valid_i = '0;
    for (int k = 0; k < 5; k++) begin
      cycle("idle", 4'b0000);
      check("idle.src_hold", 64'(cdb_src_o), FIXED ? 64'd0 : 64'd2);
    end
    set_fu(FU_BR, 1'b1, 6'h33, 32'hCAFE_F00D);
    cycle("br_after_idle", 4'b1000);

    // Reset and flush together: reset clears everything.
    load_defaults();
    reset_i = 1'b1;
    flush_i = 1'b1;
    #1;
    check("rstflush.rdy", 64'(req_ready_o), 64'd0);
    tick();
    check_cleared("rstflush");
    reset_i = 1'b0;
    flush_i = 1'b0;
    cycle("after_rst", 4'b0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
